cell_assembler: RTL

CELL_ASSEMBLER -- requirements
Module: cell_assembler

---
 rtl/cell_assembler.sv | 112 +++++++++++
 1 files changed

// File: rtl/cell_assembler.sv
`default_nettype none
// ============================================================================
// Module   : cell_assembler
// Purpose  : Packs a raster-ordered 3x3 pixel window into one of two ping-pong
//            cell buffers and hands each complete cell off with a valid/ack pair.
// Revision : 1.0 - initial release
// ============================================================================
module cell_assembler #(
    parameter int PIXEL_WIDTH = 24
) (
    input  logic                     SYSCLK,
    input  logic                     RST,
    input  logic                     CLK_En,
    input  logic                     Flush,
    input  logic [PIXEL_WIDTH-1:0]   PixelIn,
    input  logic                     PixelValid,
    output logic                     PixelReady,
    output logic [9*PIXEL_WIDTH-1:0] CellA,
    output logic [9*PIXEL_WIDTH-1:0] CellB,
    output logic                     CellAValid,
    output logic                     CellBValid,
    input  logic                     CellAAck,
    input  logic                     CellBAck,
    output logic [3:0]               FillCount
);

    localparam logic [1:0] FILL_A = 2'b00;
    localparam logic [1:0] FILL_B = 2'b01;
    localparam logic [1:0] WAIT_A = 2'b10;
    localparam logic [1:0] WAIT_B = 2'b11;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       accept;
    logic       last_pixel;
    logic       a_free;
    logic       b_free;

    assign accept     = PixelValid & PixelReady;
    assign last_pixel = accept && (FillCount == 4'd8);
    // A buffer being acknowledged this cycle already counts as free.
    assign a_free     = !CellAValid || CellAAck;
    assign b_free     = !CellBValid || CellBAck;

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state <= FILL_A;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL_A: if (last_pixel) next_state = b_free ? FILL_B : WAIT_B;
            FILL_B: if (last_pixel) next_state = a_free ? FILL_A : WAIT_A;
            WAIT_A: if (a_free)     next_state = FILL_A;
            WAIT_B: if (b_free)     next_state = FILL_B;
            default:                next_state = FILL_A;
        endcase
    end

    always_comb begin
        PixelReady = ((state == FILL_A) || (state == FILL_B)) && CLK_En && !Flush;
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            CellA      <= '0;
            CellB      <= '0;
            CellAValid <= 1'b0;
            CellBValid <= 1'b0;
            FillCount  <= 4'd0;
        end else begin
            if (CellAAck && CellAValid) CellAValid <= 1'b0;
            if (CellBAck && CellBValid) CellBValid <= 1'b0;

            if (Flush) begin
                // Only the buffer under construction is wiped; completed cells stay intact.
                FillCount <= 4'd0;
                if (state == FILL_A) begin
                    CellA <= '0;
                end else if (state == FILL_B) begin
                    CellB <= '0;
                end
            end else if (accept) begin
                for (int k = 0; k < 9; k++) begin
                    if (FillCount == 4'(k)) begin
                        if (state == FILL_A) begin
                            CellA[k*PIXEL_WIDTH +: PIXEL_WIDTH] <= PixelIn;
                        end else begin
                            CellB[k*PIXEL_WIDTH +: PIXEL_WIDTH] <= PixelIn;
                        end
                    end
                end
                if (last_pixel) begin
                    FillCount <= 4'd0;
                    if (state == FILL_A) begin
                        CellAValid <= 1'b1;
                    end else begin
                        CellBValid <= 1'b1;
                    end
                end else begin
                    FillCount <= FillCount + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
